// File: rtl/interrupt_controller_pkg.sv
// Shared SFR address map, FSM encodings and control bit positions for interrupt_controller.
package interrupt_controller_pkg;

   localparam logic [1:0] INTC_CTRL  = 2'd0;
   localparam logic [1:0] INTC_MASK  = 2'd1;
   localparam logic [1:0] INTC_PEND  = 2'd2;
   localparam logic [1:0] INTC_VBASE = 2'd3;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_REQ     = 2'd1;
   localparam logic [1:0] ST_SERVICE = 2'd2;

   localparam int GIE_BIT = 0;

endpackage

// File: rtl/intc_prio_enc.sv
// intc_prio_enc: combinational find-first-set; index 0 is the highest priority.
module intc_prio_enc #(
   parameter int N     = 8,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req_i,
   output logic [IDX_W-1:0] idx_o,
   output logic             valid_o
);

   always_comb begin
      idx_o   = '0;
      valid_o = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (req_i[i] && !valid_o) begin
            idx_o   = IDX_W'(i);
            valid_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/interrupt_controller.sv
// interrupt_controller: edge-latched, fixed-priority interrupt controller with SFR access.
// Define INTC_NESTING_EN to let a higher-priority source preempt an active handler.
module interrupt_controller
   import interrupt_controller_pkg::*;
#(
   parameter int NUM_SRC  = 8,
   parameter int ADDR_W   = 16,
   parameter int DATA_W   = 16,
   parameter int VEC_SHFT = 2
) (
   input  logic                clock,
   input  logic                nreset,
   input  logic [NUM_SRC-1:0]  irq_src,
   input  logic                sfr_wen,
   input  logic [1:0]          sfr_addr,
   input  logic [DATA_W-1:0]   sfr_wdata,
   output logic [DATA_W-1:0]   sfr_rdata,
   input  logic                int_ack,
   input  logic                int_return,
   output logic                interrupt,
   output logic [ADDR_W-1:0]   interrupt_vector_address,
   output logic                in_service
);

   localparam int IDX_W = $clog2(NUM_SRC);

   logic [NUM_SRC-1:0] prev_q;
   logic               armed_q;
   logic [NUM_SRC-1:0] pend_q, pend_d;
   logic [NUM_SRC-1:0] mask_q, mask_d;
   logic [NUM_SRC-1:0] isr_q, isr_d;
   logic               gie_q, gie_d;
   logic [ADDR_W-1:0]  vbase_q, vbase_d;
   logic [1:0]         state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [ADDR_W-1:0]  vec_q, vec_d;
   logic               irq_q, irq_d;
   logic [DATA_W-1:0]  rdata_q, rdata_d;

   logic [NUM_SRC-1:0] riseEvt, eligible, w1cMask, ackClear, idxOnehot;
   logic [IDX_W-1:0]   winIdx;
   logic               winValid;
   logic [ADDR_W-1:0]  vecCalc;
   logic               wrCtrl, wrMask, wrPend, wrVbase;

   // armed_q masks the first cycle after reset so a source already high is not seen as an edge
   assign riseEvt   = irq_src & ~prev_q & {NUM_SRC{armed_q}};
   assign eligible  = pend_q & mask_q & {NUM_SRC{gie_q}};
   assign idxOnehot = NUM_SRC'(1) << idx_q;
   assign vecCalc   = vbase_q + (ADDR_W'(winIdx) << VEC_SHFT);

   assign wrCtrl  = sfr_wen && (sfr_addr == INTC_CTRL);
   assign wrMask  = sfr_wen && (sfr_addr == INTC_MASK);
   assign wrPend  = sfr_wen && (sfr_addr == INTC_PEND);
   assign wrVbase = sfr_wen && (sfr_addr == INTC_VBASE);

   intc_prio_enc #(.N(NUM_SRC), .IDX_W(IDX_W)) u_win_enc (
      .req_i   (eligible),
      .idx_o   (winIdx),
      .valid_o (winValid)
   );

`ifdef INTC_NESTING_EN
   logic [IDX_W-1:0]   isrIdx;
   logic               isrValid;
   logic [NUM_SRC-1:0] isrLowOnehot;
   logic               preempt;

   intc_prio_enc #(.N(NUM_SRC), .IDX_W(IDX_W)) u_isr_enc (
      .req_i   (isr_q),
      .idx_o   (isrIdx),
      .valid_o (isrValid)
   );

   assign isrLowOnehot = NUM_SRC'(1) << isrIdx;
   assign preempt      = winValid && (!isrValid || (winIdx < isrIdx));
`endif

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      vec_d    = vec_q;
      irq_d    = irq_q;
      isr_d    = isr_q;
      ackClear = '0;
      case (state_q)
         ST_IDLE: begin
            if (winValid) begin
               state_d = ST_REQ;
               idx_d   = winIdx;
               vec_d   = vecCalc;
               irq_d   = 1'b1;
            end
         end
         ST_REQ: begin
            if (int_ack) begin
               state_d  = ST_SERVICE;
               ackClear = idxOnehot;
               isr_d    = isr_q | idxOnehot;
               irq_d    = 1'b0;
            end
         end
         ST_SERVICE: begin
`ifdef INTC_NESTING_EN
            // A return takes precedence; any preemption is evaluated on the following cycle
            if (int_return) begin
               isr_d = isr_q & ~isrLowOnehot;
               if (isr_d == '0) begin
                  state_d = ST_IDLE;
               end
            end else if (preempt) begin
               state_d = ST_REQ;
               idx_d   = winIdx;
               vec_d   = vecCalc;
               irq_d   = 1'b1;
            end
`else
            if (int_return) begin
               isr_d   = '0;
               state_d = ST_IDLE;
            end
`endif
         end
         default: begin
            state_d = ST_IDLE;
            irq_d   = 1'b0;
         end
      endcase
   end

   always_comb begin
      mask_d  = wrMask ? sfr_wdata[NUM_SRC-1:0] : mask_q;
      gie_d   = wrCtrl ? sfr_wdata[GIE_BIT] : gie_q;
      vbase_d = wrVbase ? ADDR_W'(sfr_wdata) : vbase_q;
      w1cMask = wrPend ? sfr_wdata[NUM_SRC-1:0] : '0;
      pend_d  = (pend_q & ~(w1cMask | ackClear)) | riseEvt;
   end

   always_comb begin
      rdata_d = '0;
      case (sfr_addr)
         INTC_CTRL:  rdata_d[GIE_BIT] = gie_q;
         INTC_MASK:  rdata_d = DATA_W'(mask_q);
         INTC_PEND:  rdata_d = DATA_W'(pend_q);
         default:    rdata_d = DATA_W'(vbase_q);
      endcase
   end

   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         prev_q  <= '0;
         armed_q <= 1'b0;
         pend_q  <= '0;
         mask_q  <= '0;
         isr_q   <= '0;
         gie_q   <= 1'b0;
         vbase_q <= '0;
         state_q <= ST_IDLE;
         idx_q   <= '0;
         vec_q   <= '0;
         irq_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         prev_q  <= irq_src;
         armed_q <= 1'b1;
         pend_q  <= pend_d;
         mask_q  <= mask_d;
         isr_q   <= isr_d;
         gie_q   <= gie_d;
         vbase_q <= vbase_d;
         state_q <= state_d;
         idx_q   <= idx_d;
         vec_q   <= vec_d;
         irq_q   <= irq_d;
         rdata_q <= rdata_d;
      end
   end

   assign sfr_rdata                = rdata_q;
   assign interrupt                = irq_q;
   assign interrupt_vector_address = vec_q;
   assign in_service               = |isr_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// tb_interrupt_controller: directed self-checking bench for interrupt_controller.
module tb_interrupt_controller;

   logic        clock = 1'b0;
   logic        nreset;
   logic [7:0]  irq_src;
   logic        sfr_wen;
   logic [1:0]  sfr_addr;
   logic [15:0] sfr_wdata;
   logic [15:0] sfr_rdata;
   logic        int_ack;
   logic        int_return;
   logic        interrupt;
   logic [15:0] interrupt_vector_address;
   logic        in_service;

   int checkCount = 0;
   int passCount  = 0;
   logic [15:0] readVal;

   localparam logic [1:0] A_CTRL = 2'd0, A_MASK = 2'd1, A_PEND = 2'd2, A_VBASE = 2'd3;

   interrupt_controller dut (
      .clock                    (clock),
      .nreset                   (nreset),
      .irq_src                  (irq_src),
      .sfr_wen                  (sfr_wen),
      .sfr_addr                 (sfr_addr),
      .sfr_wdata                (sfr_wdata),
      .sfr_rdata                (sfr_rdata),
      .int_ack                  (int_ack),
      .int_return               (int_return),
      .interrupt                (interrupt),
      .interrupt_vector_address (interrupt_vector_address),
      .in_service               (in_service)
   );

   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Drives one cycle of inputs, then returns 1 time unit after the clock edge
   task automatic applyStimulus(input logic [7:0] src, input logic wen, input logic [1:0] addr,
                                input logic [15:0] wdata, input logic ack, input logic ret);
      irq_src    = src;
      sfr_wen    = wen;
      sfr_addr   = addr;
      sfr_wdata  = wdata;
      int_ack    = ack;
      int_return = ret;
      @(posedge clock);
      #1;
      sfr_wen    = 1'b0;
      int_ack    = 1'b0;
      int_return = 1'b0;
   endtask

   task automatic idle();
      applyStimulus(irq_src, 1'b0, sfr_addr, 16'h0, 1'b0, 1'b0);
   endtask

   task automatic sfrWrite(input logic [1:0] addr, input logic [15:0] data);
      applyStimulus(irq_src, 1'b1, addr, data, 1'b0, 1'b0);
   endtask

   task automatic sfrRead(input logic [1:0] addr, output logic [15:0] data);
      applyStimulus(irq_src, 1'b0, addr, 16'h0, 1'b0, 1'b0);
      data = sfr_rdata;
   endtask

   task automatic pulseSrc(input logic [7:0] src);
      applyStimulus(src, 1'b0, sfr_addr, 16'h0, 1'b0, 1'b0);
      applyStimulus(8'h00, 1'b0, sfr_addr, 16'h0, 1'b0, 1'b0);
   endtask

   task automatic ackPulse();
      applyStimulus(irq_src, 1'b0, sfr_addr, 16'h0, 1'b1, 1'b0);
   endtask

   task automatic retPulse();
      applyStimulus(irq_src, 1'b0, sfr_addr, 16'h0, 1'b0, 1'b1);
   endtask

   task automatic waitIrq(input string tag, input int maxCycles);
      for (int i = 0; i < maxCycles && !interrupt; i++) idle();
      checkOutput(tag, {31'b0, interrupt}, 32'h1);
   endtask

   initial begin
      nreset = 1'b0;
      irq_src = '0; sfr_wen = 1'b0; sfr_addr = '0; sfr_wdata = '0;
      int_ack = 1'b0; int_return = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      checkOutput("rst_irq", {31'b0, interrupt}, 32'h0);
      checkOutput("rst_vec", {16'b0, interrupt_vector_address}, 32'h0);
      checkOutput("rst_insvc", {31'b0, in_service}, 32'h0);
      checkOutput("rst_rdata", {16'b0, sfr_rdata}, 32'h0);
      nreset = 1'b1;
      idle();

      // Single source, exact latency
      sfrWrite(A_MASK, 16'h0001);
      sfrWrite(A_CTRL, 16'h0001);
      sfrWrite(A_VBASE, 16'h0100);
      applyStimulus(8'h01, 1'b0, A_CTRL, 16'h0, 1'b0, 1'b0);
      checkOutput("t1_lat_pend", {31'b0, interrupt}, 32'h0);
      applyStimulus(8'h00, 1'b0, A_CTRL, 16'h0, 1'b0, 1'b0);
      checkOutput("t1_irq", {31'b0, interrupt}, 32'h1);
      checkOutput("t1_vec", {16'b0, interrupt_vector_address}, 32'h0100);
      ackPulse();
      checkOutput("t1_ack_irq", {31'b0, interrupt}, 32'h0);
      checkOutput("t1_ack_insvc", {31'b0, in_service}, 32'h1);
      sfrRead(A_PEND, readVal);
      checkOutput("t1_pend", {16'b0, readVal}, 32'h0);
      retPulse();
      checkOutput("t1_ret_insvc", {31'b0, in_service}, 32'h0);

      // Simultaneous sources: priority order
      sfrWrite(A_MASK, 16'h00FF);
      pulseSrc(8'h0A);
      checkOutput("t2_irq_a", {31'b0, interrupt}, 32'h1);
      checkOutput("t2_vec_src1", {16'b0, interrupt_vector_address}, 32'h0104);
      ackPulse();
      retPulse();
      waitIrq("t2_irq_b", 5);
      checkOutput("t2_vec_src3", {16'b0, interrupt_vector_address}, 32'h010C);
      ackPulse();
      retPulse();
      checkOutput("t2_insvc", {31'b0, in_service}, 32'h0);

      // Request is never withdrawn once raised
      pulseSrc(8'h04);
      checkOutput("t3_vec", {16'b0, interrupt_vector_address}, 32'h0108);
      sfrWrite(A_MASK, 16'h0000);
      sfrWrite(A_CTRL, 16'h0000);
      idle();
      idle();
      checkOutput("t3_hold_irq", {31'b0, interrupt}, 32'h1);
      checkOutput("t3_hold_vec", {16'b0, interrupt_vector_address}, 32'h0108);
      ackPulse();
      checkOutput("t3_ack_irq", {31'b0, interrupt}, 32'h0);
      retPulse();
      sfrWrite(A_CTRL, 16'h0001);
      sfrWrite(A_MASK, 16'h00FF);

      // Edge beats W1C in the same cycle
      applyStimulus(8'h20, 1'b1, A_PEND, 16'h0020, 1'b0, 1'b0);
      irq_src = 8'h00;
      sfrRead(A_PEND, readVal);
      checkOutput("t4_pend_edge_wins", {16'b0, readVal}, 32'h0020);
      waitIrq("t4_irq", 3);
      checkOutput("t4_vec", {16'b0, interrupt_vector_address}, 32'h0114);
      ackPulse();
      retPulse();

      // Plain W1C on a masked source
      sfrWrite(A_MASK, 16'h0000);
      pulseSrc(8'h40);
      sfrRead(A_PEND, readVal);
      checkOutput("t4_pend_set", {16'b0, readVal}, 32'h0040);
      sfrWrite(A_PEND, 16'h0040);
      sfrRead(A_PEND, readVal);
      checkOutput("t4_pend_w1c", {16'b0, readVal}, 32'h0000);
      checkOutput("t4_masked_irq", {31'b0, interrupt}, 32'h0);
      sfrWrite(A_MASK, 16'h00FF);

      // Higher-priority source during service
      pulseSrc(8'h10);
      checkOutput("t5_vec_src4", {16'b0, interrupt_vector_address}, 32'h0110);
      ackPulse();
      pulseSrc(8'h01);
`ifdef INTC_NESTING_EN
      checkOutput("t5_preempt_irq", {31'b0, interrupt}, 32'h1);
      checkOutput("t5_preempt_vec", {16'b0, interrupt_vector_address}, 32'h0100);
      ackPulse();
      retPulse();
      checkOutput("t5_ret1_insvc", {31'b0, in_service}, 32'h1);
      retPulse();
      checkOutput("t5_ret2_insvc", {31'b0, in_service}, 32'h0);
`else
      idle();
      idle();
      checkOutput("t5_no_nest_irq", {31'b0, interrupt}, 32'h0);
      checkOutput("t5_no_nest_insvc", {31'b0, in_service}, 32'h1);
      retPulse();
      waitIrq("t5_irq_after_ret", 3);
      checkOutput("t5_vec_src0", {16'b0, interrupt_vector_address}, 32'h0100);
      ackPulse();
      retPulse();
      checkOutput("t5_insvc", {31'b0, in_service}, 32'h0);
`endif

      // Asynchronous reset while a request is outstanding
      pulseSrc(8'h04);
      checkOutput("t6_irq_before", {31'b0, interrupt}, 32'h1);
      irq_src = 8'h80;
      #2;
      nreset = 1'b0;
      #1;
      checkOutput("t6_irq_async", {31'b0, interrupt}, 32'h0);
      repeat (2) @(posedge clock);
      #1;
      nreset = 1'b1;
      idle();
      idle();
      checkOutput("t6_irq_after", {31'b0, interrupt}, 32'h0);
      checkOutput("t6_insvc", {31'b0, in_service}, 32'h0);
      sfrRead(A_CTRL, readVal);
      checkOutput("t6_ctrl", {16'b0, readVal}, 32'h0);
      sfrRead(A_MASK, readVal);
      checkOutput("t6_mask", {16'b0, readVal}, 32'h0);
      sfrRead(A_PEND, readVal);
      checkOutput("t6_pend_held_src", {16'b0, readVal}, 32'h0);
      sfrRead(A_VBASE, readVal);
      checkOutput("t6_vbase", {16'b0, readVal}, 32'h0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
